// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file for the multi-cycle MIPS32 datapath. It has two
//   combinational read ports and one write port, and it can forward a
//   same-cycle write to a matching read port. Register 0 can be
//   hardwired to zero. A per-register pending bit marks each register
//   whose multi-cycle producer (load, mult/div) has not yet written back.
//
// Ports
//   Clk                      clock; all state changes on the rising edge
//   Reset                    synchronous, active-high reset
//   ReadReg1/2, ReadData1/2  read indices and combinational read data
//   Pending1/2               read index has an outstanding reserved write
//   RegWrite, WriteReg,
//   WriteData                write port
//   Reserve, ReserveReg      mark a destination as awaiting writeback
//   PendingCount             registered popcount of the pending bits
//   PendingAny               registered PendingCount != 0
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Pending1,
  output logic              Pending2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ReserveReg,
  output logic [ADDR_W:0]   PendingCount,
  output logic              PendingAny
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam bit ZeroEn = (ZERO_REG != 0);
  localparam bit BypEn  = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pendingNext;
  logic [ADDR_W:0]   pendingCountQ;
  logic [ADDR_W:0]   countNext;
  logic              pendingAnyQ;

  logic writeEn;
  logic reserveEn;
  logic countInc;
  logic countDec;

  // A write or reserve that targets the hardwired zero register is dropped.
  assign writeEn   = RegWrite && !(ZeroEn && (WriteReg == '0));
  assign reserveEn = Reserve  && !(ZeroEn && (ReserveReg == '0));

  // The clear is applied before the set, so a reserve issued in the same
  // cycle as a writeback to that register keeps the bit set: a newer
  // producer is now in flight.
  always_comb begin
    pendingNext = pending;
    if (writeEn) pendingNext[WriteReg] = 1'b0;
    if (reserveEn) pendingNext[ReserveReg] = 1'b1;
  end

  // The count tracks 0->1 and 1->0 transitions of the pending bits. The
  // set and the clear can hit two different registers in one cycle and
  // cancel out, and the count cannot wrap.
  assign countInc = reserveEn && !pending[ReserveReg];
  assign countDec = writeEn && pending[WriteReg] &&
                    !(reserveEn && (ReserveReg == WriteReg));
  assign countNext = pendingCountQ + {{ADDR_W{1'b0}}, countInc}
                                   - {{ADDR_W{1'b0}}, countDec};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending       <= '0;
      pendingCountQ <= '0;
      pendingAnyQ   <= 1'b0;
    end else begin
      if (writeEn) regs[WriteReg] <= WriteData;
      pending       <= pendingNext;
      pendingCountQ <= countNext;
      pendingAnyQ   <= (countNext != '0);
    end
  end

  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] val;
    val = regs[idx];
    if (BypEn && writeEn && (WriteReg == idx)) val = WriteData;
    if (ZeroEn && (idx == '0)) val = '0;
    return val;
  endfunction

  // If a write is landing on the register this cycle, its producer has
  // completed. With bypass, the data is already on the read port.
  function automatic logic pendPort(input logic [ADDR_W-1:0] idx);
    logic val;
    val = pending[idx];
    if (BypEn && writeEn && (WriteReg == idx)) val = 1'b0;
    if (ZeroEn && (idx == '0)) val = 1'b0;
    return val;
  endfunction

  assign ReadData1    = Reset ? '0   : readPort(ReadReg1);
  assign ReadData2    = Reset ? '0   : readPort(ReadReg2);
  assign Pending1     = Reset ? 1'b0 : pendPort(ReadReg1);
  assign Pending2     = Reset ? 1'b0 : pendPort(ReadReg2);
  assign PendingCount = pendingCountQ;
  assign PendingAny   = Reset ? 1'b0 : pendingAnyQ;

endmodule
